// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter
module ps2_host_tx #(
    parameter int CLK_HZ       = 25000000,
    parameter int INHIBIT_CYC  = CLK_HZ / 10000,
    parameter int START_TO_CYC = CLK_HZ * 15 / 1000,
    parameter int FRAME_TO_CYC = CLK_HZ * 2 / 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err_timeout
);

    localparam int CNT_MAX_A = (INHIBIT_CYC > START_TO_CYC) ? INHIBIT_CYC : START_TO_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > FRAME_TO_CYC) ? CNT_MAX_A : FRAME_TO_CYC;
    localparam int CW        = $clog2(CNT_MAX + 1);

    // INHIBIT lasts INHIBIT_CYC cycles; REQ adds the final clock-low cycle
    localparam logic [CW-1:0] INH_LOAD   = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] START_LOAD = CW'(START_TO_CYC);
    localparam logic [CW-1:0] FRAME_LOAD = CW'(FRAME_TO_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_WAIT_FE,
        S_BITS,
        S_WAIT_IDLE,
        S_ABORT,
        S_FIN
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          clk_s1;
    logic          clk_s2;
    logic          clk_prev;
    logic          dat_s1;
    logic          dat_s2;
    logic          fe;

    logic [9:0]    frame;
    logic [3:0]    bitcnt;
    logic [CW-1:0] cnt;
    logic          dat_bit;
    logic          expired;

    assign fe      = clk_prev & ~clk_s2;
    assign expired = (cnt == '0);
    assign busy    = ~tx_ready;

    // two-flop synchronizers on both pads plus one history flop for edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat_in;
            dat_s2   <= dat_s1;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state and line/handshake outputs; fe has priority over timer expiry
    always_comb begin
        state_next = state;
        tx_ready   = 1'b0;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    state_next = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (expired) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = 1'b1;
                state_next = S_WAIT_FE;
            end
            S_WAIT_FE: begin
                ps2_dat_oe = 1'b1;
                if (fe) begin
                    state_next = S_BITS;
                end else if (expired) begin
                    state_next = S_ABORT;
                end
            end
            S_BITS: begin
                ps2_dat_oe = dat_bit;
                if (fe && (bitcnt == 4'd10)) begin
                    state_next = S_WAIT_IDLE;
                end else if (!fe && expired) begin
                    state_next = S_ABORT;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s2 && dat_s2) begin
                    state_next = S_FIN;
                end else if (expired) begin
                    state_next = S_ABORT;
                end
            end
            S_ABORT: begin
                state_next = S_FIN;
            end
            S_FIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // frame shift register, bit counter, shared timer and sticky result flags
    always_ff @(posedge clk) begin
        if (reset) begin
            frame       <= '0;
            bitcnt      <= '0;
            cnt         <= '0;
            dat_bit     <= 1'b0;
            ack_ok      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        frame       <= {1'b1, ~^tx_data, tx_data};
                        cnt         <= INH_LOAD;
                        bitcnt      <= '0;
                        dat_bit     <= 1'b0;
                        ack_ok      <= 1'b0;
                        err_timeout <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    if (!expired) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_REQ: begin
                    cnt <= START_LOAD;
                end
                S_WAIT_FE: begin
                    if (fe) begin
                        dat_bit <= ~frame[0];
                        frame   <= {1'b0, frame[9:1]};
                        bitcnt  <= 4'd1;
                        cnt     <= FRAME_LOAD;
                    end else if (!expired) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_BITS: begin
                    if (!expired) begin
                        cnt <= cnt - CW'(1);
                    end
                    if (fe) begin
                        if (bitcnt < 4'd10) begin
                            dat_bit <= ~frame[0];
                            frame   <= {1'b0, frame[9:1]};
                            bitcnt  <= bitcnt + 4'd1;
                        end else begin
                            ack_ok  <= ~dat_s2;
                            dat_bit <= 1'b0;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (!expired) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_ABORT: begin
                    err_timeout <= 1'b1;
                    ack_ok      <= 1'b0;
                    dat_bit     <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

    localparam int I = 25;
    localparam int S = 400;
    localparam int F = 600;
    localparam int H = 10;
    localparam int LIMIT = 3000;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err_timeout;
    logic       dev_clk;
    logic       dev_dat;

    int checks = 0;
    int errors = 0;
    int case_id = 0;

    // open-collector wired-AND of host and device drivers
    assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
    assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_HZ(25000000),
        .INHIBIT_CYC(I),
        .START_TO_CYC(S),
        .FRAME_TO_CYC(F)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy(busy),
        .done(done),
        .ack_ok(ack_ok),
        .err_timeout(err_timeout)
    );

    typedef struct {
        logic [7:0] data;
        int         mode;
        bit         hold;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL case %0d %s: got %0h expected %0h", case_id, name, act, exp);
        end
    endtask

    // expected wire sequence: start, d0..d7, odd parity, stop (index 0 = start)
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    // device model; mode 0 acks, 1 no ack, 2 stops after 5 falling edges, 3 never clocks
    task automatic dev_run(input int mode, output logic [10:0] bits, output bit rts);
        rts  = 1'b0;
        bits = '0;
        if (mode == 3) return;
        for (int n = 0; n < LIMIT && !rts; n++) begin
            tick();
            if (ps2_clk_in && !ps2_dat_in) rts = 1'b1;
        end
        if (!rts) return;
        repeat (H) tick();
        bits[0] = ps2_dat_in;
        for (int i = 1; i <= 11; i++) begin
            if (mode == 2 && i == 6) return;
            if (i == 11 && mode == 0) begin
                dev_dat = 1'b0;
                repeat (H / 2) tick();
            end
            dev_clk = 1'b0;
            repeat (H) tick();
            dev_clk = 1'b1;
            if (i <= 10) bits[i] = ps2_dat_in;
            repeat (H) tick();
            dev_dat = 1'b1;
        end
    endtask

    // host side: request a byte and watch the handshake until done
    task automatic host_run(input logic [7:0] data, input bit hold,
                            output int cyc, output int clk_low, output bit dat_first,
                            output bit busy_ok, output bit got_done, output bit first_clk,
                            output bit flags_clr);
        tx_data  = data;
        tx_valid = 1'b1;
        tick();
        if (!hold) tx_valid = 1'b0;
        cyc       = 0;
        clk_low   = 0;
        dat_first = 1'b0;
        busy_ok   = 1'b1;
        got_done  = 1'b0;
        first_clk = ps2_clk_oe;
        flags_clr = !ack_ok && !err_timeout;
        while (!got_done && cyc < LIMIT) begin
            if (ps2_clk_oe) clk_low++;
            if (ps2_clk_oe && ps2_dat_oe) dat_first = 1'b1;
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (!busy || tx_ready) busy_ok = 1'b0;
                if (hold) tx_data = 8'($urandom);
                tick();
                cyc++;
            end
        end
        tx_valid = 1'b0;
    endtask

    task automatic run_case(input logic [7:0] data, input int mode, input bit hold);
        logic [10:0] bits;
        bit rts, dat_first, busy_ok, got_done, first_clk, flags_clr;
        int cyc, clk_low;
        bit oe_low;
        case_id++;
        fork
            dev_run(mode, bits, rts);
            host_run(data, hold, cyc, clk_low, dat_first, busy_ok, got_done, first_clk, flags_clr);
        join
        oe_low = !ps2_clk_oe && !ps2_dat_oe;
        check("done_seen", 32'(got_done), 32'd1);
        if (got_done) begin
            check("ack_ok", 32'(ack_ok), 32'(mode == 0));
            check("err_timeout", 32'(err_timeout), 32'(mode == 3));
        end
        check("busy_whole_xfer", 32'(busy_ok), 32'd1);
        check("clk_oe_next_edge", 32'(first_clk), 32'd1);
        check("flags_cleared", 32'(flags_clr), 32'd1);
        check("clk_low_cycles", 32'(clk_low), 32'(I + 1));
        check("dat_before_release", 32'(dat_first), 32'd1);
        if (mode != 3) begin
            check("rts_seen", 32'(rts), 32'd1);
            check("wire_bits", 32'(bits), 32'(exp_frame(data)));
        end else begin
            check("timeout_cyc_in_window",
                  32'(cyc >= I + S + 1 && cyc <= I + S + 5), 32'd1);
            check("oe_low_at_done", 32'(oe_low), 32'd1);
        end
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after_done", 32'(tx_ready), 32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        logic [10:0] bits;
        bit rts;
        bit saw_done;

        vecs[0] = '{data: 8'hED, mode: 0, hold: 1'b0};
        vecs[1] = '{data: 8'hFF, mode: 0, hold: 1'b0};
        vecs[2] = '{data: 8'h00, mode: 3, hold: 1'b0};
        vecs[3] = '{data: 8'hA5, mode: 1, hold: 1'b0};
        vecs[4] = '{data: 8'h3C, mode: 0, hold: 1'b1};
        vecs[5] = '{data: 8'h01, mode: 1, hold: 1'b1};

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        repeat (3) tick();
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack_ok", 32'(ack_ok), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        reset = 1'b0;
        tick();

        // device clock activity while idle must be ignored
        saw_done = 1'b0;
        repeat (3) begin
            dev_clk = 1'b0;
            repeat (H) begin tick(); if (done || !tx_ready || ps2_clk_oe || ps2_dat_oe) saw_done = 1'b1; end
            dev_clk = 1'b1;
            repeat (H) begin tick(); if (done || !tx_ready || ps2_clk_oe || ps2_dat_oe) saw_done = 1'b1; end
        end
        check("idle_edges_ignored", 32'(saw_done), 32'd0);

        for (int k = 0; k < 6; k++) begin
            run_case(vecs[k].data, vecs[k].mode, vecs[k].hold);
        end

        for (int r = 0; r < 4; r++) begin
            run_case(8'($urandom), int'($urandom_range(0, 1)), 1'b0);
        end

        // reset in the middle of 0x55, then an immediate 0xF4
        case_id++;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        dev_run(2, bits, rts);
        check("rst_mid_rts", 32'(rts), 32'd1);
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_mid_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check("rst_mid_ready", 32'(tx_ready), 32'd1);
        check("rst_mid_no_done", 32'(done), 32'd0);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (5) begin tick(); if (done) saw_done = 1'b1; end
        check("rst_mid_no_done_later", 32'(saw_done), 32'd0);
        run_case(8'hF4, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
